axis_wrr_pkt_arb: RTL
=====================

# axis_wrr_pkt_arb

Packet-aware weighted round-robin arbiter that merges `MASTER_NUM` AXI-Stream sources onto one AXI-Stream sink. A grant is locked from a packet's first beat through its `tlast` beat, so packets are never interleaved. Each source may send up to `weight` consecutive packets per turn before the grant rotates. It sits in front of shared stream consumers such as DMA writers and UART/Ethernet TX, where whole-packet integrity and tunable bandwidth shares are required.

## Interface
- `MASTER_NUM`, 4: number of sources; must be ≥ 2.
- `DATA_WIDTH`, 32: tdata width.
- `WEIGHT_WIDTH`, 4: width of each per-source weight.
- `PTR_WIDTH`, derived: `$clog2(MASTER_NUM)`.

Ports:
- `clk_i` in 1: clock. One clock; all logic is on its rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `weight_i` in `MASTER_NUM*WEIGHT_WIDTH`: packets per turn for each source. Source i uses slice `[i*WEIGHT_WIDTH +: WEIGHT_WIDTH]`. A value of 0 disables that source.
- `s_tvalid_i` in `MASTER_NUM`: per-source tvalid.
- `s_tready_o` out `MASTER_NUM`: per-source tready.
- `s_tdata_i` in `MASTER_NUM*DATA_WIDTH`: per-source tdata, packed the same way as `weight_i`.
- `s_tlast_i` in `MASTER_NUM`: per-source tlast.
- `m_tvalid_o` out 1: sink tvalid.
- `m_tready_i` in 1: sink tready.
- `m_tdata_o` out `DATA_WIDTH`: sink tdata.
- `m_tlast_o` out 1: sink tlast.
- `m_tuser_o` out `PTR_WIDTH`: index of the granted source.
- `busy_o` out 1: high while a grant is locked.

## Operation
- **FSM states:** `ARB_IDLE` and `ARB_LOCK`.
- **Registers:**
  - `state`
  - `sel` (`PTR_WIDTH`): granted or last-granted source.
  - `credit` (`WEIGHT_WIDTH`): packets left in the current turn after the one in flight.
- **Eligible set:** `elig[i] = s_tvalid_i[i] & (weight_i[i] != 0)`.
- **`ARB_IDLE` decision, one cycle:**
  - If `credit != 0` and `elig[sel]`: re-grant `sel`, `credit <= credit-1`, go to `ARB_LOCK`.
  - Else if any `elig`: pick the first eligible index scanning `sel+1, sel+2, …` with modulo wrap, ending at `sel` itself. Set `sel <=` winner, `credit <= weight_i[winner]-1`, go to `ARB_LOCK`.
  - Else stay in `ARB_IDLE` and hold `sel` and `credit`.
  - Credit left when another source wins is forfeited, because it is overwritten.
- **`ARB_LOCK`:**
  - `s_tready_o[sel] = m_tready_i`; all other `s_tready_o` bits are 0.
  - `m_tvalid_o = s_tvalid_i[sel]`. `m_tdata_o` and `m_tlast_o` are muxed from `sel`. `m_tuser_o = sel`.
  - On a handshake with `s_tlast_i[sel] = 1`, go to `ARB_IDLE`.
  - If the source drops tvalid mid-packet, the lock is held and `m_tvalid_o` stays low until the source resumes.
- **`ARB_IDLE` outputs:** `m_tvalid_o` = 0, all `s_tready_o` = 0, `m_tdata_o` = 0, `m_tlast_o` = 0.
- **Sampling:** `weight_i` is sampled only at the grant decision. Changes while in `ARB_LOCK` take effect at the next `ARB_IDLE` decision.
- **All weights zero:** the block never grants.

## Timing
- **Reset values:** `state = ARB_IDLE`, `sel = MASTER_NUM-1` (so the first scan starts at source 0), `credit = 0`. All outputs are 0 during and after reset until the first grant.
- **Grant latency:** a request first seen in `ARB_IDLE` at cycle t gets `m_tvalid_o` at cycle t+1.
- **Datapath:** sink signals are combinational from the source while in `ARB_LOCK`, with zero latency.
- **Throughput:** a packet of N beats takes N+1 cycles, including one arbitration bubble per packet, even on a same-source re-grant.
- **Single-beat packet** (tlast on its first beat): `ARB_LOCK` lasts one cycle when `m_tready_i` = 1.
- **Reset mid-packet:** return to `ARB_IDLE` on the next edge. The partial packet is abandoned and no tlast is emitted.
- **No output-side combinational loop:** `s_tready_o` does not depend on any `s_tvalid_i`.

## Structure
- Package `axis_arb_pkg`:
  - `typedef enum logic {ARB_IDLE, ARB_LOCK} arb_state_t`.
  - Helper function `next_idx(idx, n)` returning `(idx+1) % n`.
- Sub-module `axis_rr_picker`, purely combinational and reusable by other arbiters:
  - Inputs: `req[MASTER_NUM]`, `base[PTR_WIDTH]`.
  - Outputs: `valid`, `idx[PTR_WIDTH]`.
  - Scans starting at `base+1`, with wrap.
- The top level holds the FSM, the `credit`/`sel` registers and the output mux.

## Test plan
- **Reset defaults:** after reset, all sources idle → `m_tvalid_o`=0, `s_tready_o`=0000, `busy_o`=0.
- **Plain round-robin:** weights all 1, sources 0–3 each continuously offer 3-beat packets → sink order 0,1,2,3,0 by `m_tuser_o`, each packet contiguous, 4 cycles per packet with `m_tready_i`=1.
- **Weighted shares:** weights {2,1,0,0}, sources 0 and 1 always valid → packet order 0,0,1,0,0,1. Source 2 offering traffic with weight 0 is never granted and its `s_tready_o` stays 0.
- **Backpressure and source stall:** `m_tready_i` toggled 1010… mid-packet and source tvalid dropped for 2 cycles → no beats lost or duplicated, `busy_o` stays 1, and no other source is granted until tlast.
- **Credit forfeit:** weights {3,1,1,1}; source 0 sends one packet then goes idle while source 1 is waiting → grant goes to 1. Source 0 returning later starts a new turn with 3 packets.
- **Reset mid-packet and weight change:** assert `rst_i` on beat 2 of a 5-beat packet → `m_tvalid_o`=0 next cycle and the first post-reset grant goes to the lowest-index valid source. Separately, change `weight_i` during `ARB_LOCK` → the current turn is unaffected and the new weight applies from the next decision.

Source files
------------

// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the AXI-Stream packet arbiters.
package axis_arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_LOCK} arb_state_t;

    // Next index in a ring of n entries.
    function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/axis_wrr_pkt_arb_if.sv
// Bundle of the per-source AXI-Stream inputs and the merged sink output.
interface axis_wrr_pkt_arb_if #(
    parameter int unsigned MASTER_NUM = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned PTR_WIDTH  = $clog2(MASTER_NUM)
) ();

    logic [MASTER_NUM-1:0]            s_tvalid;
    logic [MASTER_NUM-1:0]            s_tready;
    logic [MASTER_NUM*DATA_WIDTH-1:0] s_tdata;
    logic [MASTER_NUM-1:0]            s_tlast;

    logic                             m_tvalid;
    logic                             m_tready;
    logic [DATA_WIDTH-1:0]            m_tdata;
    logic                             m_tlast;
    logic [PTR_WIDTH-1:0]             m_tuser;

    // Arbiter side: accepts the sources and drives the sink.
    modport master (
        input  s_tvalid, s_tdata, s_tlast, m_tready,
        output s_tready, m_tvalid, m_tdata, m_tlast, m_tuser
    );

    // Environment side: drives the sources and backpressures the sink.
    modport slave (
        output s_tvalid, s_tdata, s_tlast, m_tready,
        input  s_tready, m_tvalid, m_tdata, m_tlast, m_tuser
    );

endinterface

// File: rtl/axis_rr_picker.sv
// Combinational round-robin picker: first set request after base_i, wrapping.
module axis_rr_picker
    import axis_arb_pkg::*;
#(
    parameter int unsigned MASTER_NUM = 4,
    parameter int unsigned PTR_WIDTH  = $clog2(MASTER_NUM)
) (
    input  logic [MASTER_NUM-1:0] req_i,
    input  logic [PTR_WIDTH-1:0]  base_i,
    output logic                  valid_o,
    output logic [PTR_WIDTH-1:0]  idx_o
);

    // Scan base+1 .. base (inclusive, last) and keep the first hit.
    always_comb begin
        int unsigned cand;
        valid_o = 1'b0;
        idx_o   = '0;
        cand    = 32'(base_i);
        for (int unsigned k = 0; k < MASTER_NUM; k++) begin
            cand = next_idx(cand, MASTER_NUM);
            if (!valid_o && req_i[PTR_WIDTH'(cand)]) begin
                valid_o = 1'b1;
                idx_o   = PTR_WIDTH'(cand);
            end
        end
    end

endmodule

// File: rtl/axis_wrr_pkt_arb.sv
// Packet-aware weighted round-robin AXI-Stream arbiter. A grant is held from the
// first beat to tlast; a source may take up to weight packets per turn.
module axis_wrr_pkt_arb
    import axis_arb_pkg::*;
#(
    parameter int unsigned MASTER_NUM   = 4,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned WEIGHT_WIDTH = 4
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [MASTER_NUM*WEIGHT_WIDTH-1:0] weight_i,
    axis_wrr_pkt_arb_if.master                 bus_io,
    output logic                               busy_o
);

    localparam int unsigned PTR_WIDTH = $clog2(MASTER_NUM);

    arb_state_t              state_q, state_d;
    logic [PTR_WIDTH-1:0]    sel_q, sel_d;
    logic [WEIGHT_WIDTH-1:0] credit_q, credit_d;

    logic [MASTER_NUM-1:0]   elig;
    logic                    pick_valid;
    logic [PTR_WIDTH-1:0]    pick_idx;
    logic [WEIGHT_WIDTH-1:0] pick_weight;
    logic                    last_hs;

    // A source may compete only if it is requesting and not disabled by a zero weight.
    always_comb begin
        elig = '0;
        for (int unsigned i = 0; i < MASTER_NUM; i++) begin
            elig[i] = bus_io.s_tvalid[i] & (weight_i[i*WEIGHT_WIDTH +: WEIGHT_WIDTH] != '0);
        end
    end

    axis_rr_picker #(
        .MASTER_NUM (MASTER_NUM),
        .PTR_WIDTH  (PTR_WIDTH)
    ) u_picker (
        .req_i   (elig),
        .base_i  (sel_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    assign pick_weight = weight_i[int'(pick_idx)*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    assign last_hs     = bus_io.s_tvalid[sel_q] & bus_io.m_tready & bus_io.s_tlast[sel_q];

    // Grant decision in IDLE (re-grant on remaining credit, else rotate); release on tlast.
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        credit_d = credit_q;
        unique case (state_q)
            ARB_IDLE: begin
                if ((credit_q != '0) && elig[sel_q]) begin
                    credit_d = credit_q - WEIGHT_WIDTH'(1);
                    state_d  = ARB_LOCK;
                end else if (pick_valid) begin
                    // Any credit left by the previous owner is dropped here.
                    sel_d    = pick_idx;
                    credit_d = pick_weight - WEIGHT_WIDTH'(1);
                    state_d  = ARB_LOCK;
                end
            end
            ARB_LOCK: begin
                if (last_hs) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // Route the granted source to the sink; everything is quiet while idle.
    always_comb begin
        bus_io.s_tready = '0;
        bus_io.m_tvalid = 1'b0;
        bus_io.m_tdata  = '0;
        bus_io.m_tlast  = 1'b0;
        bus_io.m_tuser  = '0;
        if (state_q == ARB_LOCK) begin
            bus_io.s_tready[sel_q] = bus_io.m_tready;
            bus_io.m_tvalid        = bus_io.s_tvalid[sel_q];
            bus_io.m_tdata         = bus_io.s_tdata[int'(sel_q)*DATA_WIDTH +: DATA_WIDTH];
            bus_io.m_tlast         = bus_io.s_tlast[sel_q];
            bus_io.m_tuser         = sel_q;
        end
    end

    assign busy_o = (state_q == ARB_LOCK);

    // State and grant registers; sel resets to the last index so source 0 is scanned first.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ARB_IDLE;
            sel_q    <= PTR_WIDTH'(MASTER_NUM - 1);
            credit_q <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            credit_q <= credit_d;
        end
    end

endmodule
